anneal_seq: RTL and testbench
=============================

Name: anneal_seq

Overview:
- Top-level iteration sequencer that drives the replica node array.
- Each iteration runs three phases in order: an optimisation phase, an exponent-evaluation phase, and a replica-exchange strobe with even/odd parity.
- Sits directly upstream of every node instance and broadcasts the same phase controls to all replicas.
- Host software starts a run with an iteration count and polls busy/done.

Parameters:
- OPT_CYCLES, 16, cycles opt_run is held high per iteration (≥1)
- EXP_CYCLES, 18, cycles exp_run is held high per iteration (≥1)
- ITER_W, 24, width of the iteration counter

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle run request; sampled only in IDLE
- abort  in  1  synchronous abort; highest priority after reset
- iter_num  in  ITER_W  iterations to run; sampled with start
- recip_write  in  1  load exp_recip register; ignored while busy
- recip_wdata  in  17  reciprocal-temperature value
- busy  out  1  high from the cycle after start through the done cycle
- done  out  1  one-cycle pulse at run completion
- iter_count  out  ITER_W  index of the current iteration (0-based)
- opt_run  out  1  optimisation enable to nodes
- opt_sel  out  1  0 = or-opt, 1 = two-opt; toggles each iteration, starts at 0
- exp_init  out  1  one-cycle exponent-unit init
- exp_run  out  1  exponent-unit run window
- exp_fin  out  1  one-cycle exponent-unit finish
- exp_recip  out  17  registered reciprocal, stable whenever busy
- exch_valid  out  1  one-cycle replica-exchange strobe
- exch_parity  out  1  iter_count[0] latched with exch_valid; 0 = even pairs, 1 = odd pairs

Behaviour:
- All outputs are registered.
- Reset values: every output 0; exp_recip 0; state IDLE.
- FSM states: IDLE, OPT, EXP_INIT, EXP_RUN, EXP_FIN, EXCH, DONE.
- IDLE:
  - start=1 with iter_num≠0: latch iter_num, clear iter_count and opt_sel, go to OPT.
  - start=1 with iter_num=0: go to DONE directly; no opt_run/exp/exch activity.
- OPT:
  - opt_run=1 for exactly OPT_CYCLES cycles, counted by an internal down-counter.
  - Then go to EXP_INIT.
- EXP_INIT: exp_init=1 for 1 cycle, then EXP_RUN.
- EXP_RUN: exp_run=1 for exactly EXP_CYCLES cycles, then EXP_FIN.
- EXP_FIN: exp_fin=1 for 1 cycle, then EXCH.
- EXCH:
  - exch_valid=1 and exch_parity=iter_count[0] for 1 cycle.
  - If iter_count == latched iter_num−1: go to DONE.
  - Otherwise: iter_count++, opt_sel toggles, go to OPT.
- DONE: done=1 and busy=1 for 1 cycle, then IDLE with busy=0. iter_count holds its final value until the next start.
- Timing, with start sampled at cycle 0:
  - opt_run in cycles 1..OPT_CYCLES.
  - Full iteration length = OPT_CYCLES+EXP_CYCLES+3 cycles (37 at defaults).
- Phase signals are mutually exclusive: at most one of opt_run/exp_init/exp_run/exp_fin/exch_valid/done is high in any cycle.
- start while busy is ignored; latched iter_num is unaffected.
- recip_write:
  - In IDLE: exp_recip updates the next cycle.
  - While busy: ignored.
  - Same cycle as start in IDLE: the write takes effect, and the new value is visible from cycle 1.
- abort=1 in any non-IDLE state: next cycle state is IDLE, all strobes and busy go 0, and done is NOT pulsed. abort in IDLE has no effect. abort and start in the same IDLE cycle: start wins.
- Asynchronous reset mid-run: everything returns to reset values immediately; exp_recip is cleared.
- Iteration counter: iter_count wraps never, because the terminal compare precedes the increment. iter_num = 2^ITER_W−1 is legal.

Test Plan:
- Reset release, then start with iter_num=1 at cycle 0 -> opt_run cycles 1–16, exp_init 17, exp_run 18–35, exp_fin 36, exch_valid 37 with parity 0, done 38, busy low 39.
- iter_num=2 -> second iteration has opt_sel=1 and exch parity 1 at cycle 74, done at 75; iter_count reads 1 after the run.
- iter_num=0 with start -> busy=1 and done=1 at cycle 1; no opt_run/exp_*/exch_valid ever asserted.
- recip_write 0x1ABCD in IDLE, start, then recip_write 0x00001 at cycle 20 -> exp_recip stays 0x1ABCD for the whole run.
- iter_num=3, abort at cycle 50 -> all outputs 0 from cycle 51, no done pulse. A new start at cycle 60 restarts from iter_count=0 with opt_sel=0.
- start pulsed again at cycle 10 of an iter_num=1 run, plus async reset asserted at cycle 20 -> second start ignored (done still at 38 in the reset-free variant); with reset, outputs are 0 immediately and the FSM is in IDLE.

Source files
------------

// File: rtl/anneal_seq_if.sv
// Host/node-array bundle for the anneal iteration sequencer.
// master = host side driving run requests; slave = the sequencer itself.
interface anneal_seq_if #(
   parameter int ITER_W = 24
);
   logic              start;
   logic              abort;
   logic [ITER_W-1:0] iter_num;
   logic              recip_write;
   logic [16:0]       recip_wdata;
   logic              busy;
   logic              done;
   logic [ITER_W-1:0] iter_count;
   logic              opt_run;
   logic              opt_sel;
   logic              exp_init;
   logic              exp_run;
   logic              exp_fin;
   logic [16:0]       exp_recip;
   logic              exch_valid;
   logic              exch_parity;

   modport master (
      output start, abort, iter_num, recip_write, recip_wdata,
      input  busy, done, iter_count, opt_run, opt_sel, exp_init, exp_run,
             exp_fin, exp_recip, exch_valid, exch_parity
   );

   modport slave (
      input  start, abort, iter_num, recip_write, recip_wdata,
      output busy, done, iter_count, opt_run, opt_sel, exp_init, exp_run,
             exp_fin, exp_recip, exch_valid, exch_parity
   );
endinterface

// File: rtl/anneal_seq.sv
// Iteration sequencer: per iteration runs optimisation, exponent evaluation and a
// parity-alternating replica-exchange strobe, broadcast to every replica node.
module anneal_seq #(
   parameter int OPT_CYCLES = 16,
   parameter int EXP_CYCLES = 18,
   parameter int ITER_W     = 24
) (
   input  logic       clk_i,
   input  logic       reset_i,
   anneal_seq_if.slave bus_io
);

   localparam int MAX_CYC = (OPT_CYCLES > EXP_CYCLES) ? OPT_CYCLES : EXP_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] OPT_LOAD = CNT_W'(OPT_CYCLES - 1);
   localparam logic [CNT_W-1:0] EXP_LOAD = CNT_W'(EXP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_OPT, S_EXP_INIT, S_EXP_RUN, S_EXP_FIN, S_EXCH, S_DONE
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ITER_W-1:0] iter_num_q;
   logic [ITER_W-1:0] iter_count_q;
   logic [ITER_W-1:0] iter_count_d;
   logic              last_iter_d;
   logic              busy_q;
   logic              done_q;
   logic              opt_run_q;
   logic              opt_sel_q;
   logic              exp_init_q;
   logic              exp_run_q;
   logic              exp_fin_q;
   logic [16:0]       exp_recip_q;
   logic              exch_valid_q;
   logic              exch_parity_q;

   // Terminal compare against iter_num-1 happens before any increment, so the
   // counter never wraps even for iter_num = all-ones.
   assign iter_count_d = iter_count_q + ITER_W'(1);
   assign last_iter_d  = (iter_count_q == (iter_num_q - ITER_W'(1)));

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         iter_num_q    <= '0;
         iter_count_q  <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         opt_run_q     <= 1'b0;
         opt_sel_q     <= 1'b0;
         exp_init_q    <= 1'b0;
         exp_run_q     <= 1'b0;
         exp_fin_q     <= 1'b0;
         exp_recip_q   <= '0;
         exch_valid_q  <= 1'b0;
         exch_parity_q <= 1'b0;
      end else begin
         opt_run_q    <= 1'b0;
         exp_init_q   <= 1'b0;
         exp_run_q    <= 1'b0;
         exp_fin_q    <= 1'b0;
         exch_valid_q <= 1'b0;
         done_q       <= 1'b0;

         if (bus_io.abort && (state_q != S_IDLE)) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            iter_count_q  <= '0;
            opt_sel_q     <= 1'b0;
            exch_parity_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (bus_io.recip_write) begin
                     exp_recip_q <= bus_io.recip_wdata;
                  end
                  if (bus_io.start) begin
                     busy_q       <= 1'b1;
                     iter_count_q <= '0;
                     opt_sel_q    <= 1'b0;
                     if (bus_io.iter_num != '0) begin
                        iter_num_q <= bus_io.iter_num;
                        cnt_q      <= OPT_LOAD;
                        opt_run_q  <= 1'b1;
                        state_q    <= S_OPT;
                     end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end
                  end
               end
               S_OPT: begin
                  if (cnt_q == '0) begin
                     exp_init_q <= 1'b1;
                     state_q    <= S_EXP_INIT;
                  end else begin
                     cnt_q     <= cnt_q - CNT_W'(1);
                     opt_run_q <= 1'b1;
                  end
               end
               S_EXP_INIT: begin
                  cnt_q     <= EXP_LOAD;
                  exp_run_q <= 1'b1;
                  state_q   <= S_EXP_RUN;
               end
               S_EXP_RUN: begin
                  if (cnt_q == '0) begin
                     exp_fin_q <= 1'b1;
                     state_q   <= S_EXP_FIN;
                  end else begin
                     cnt_q     <= cnt_q - CNT_W'(1);
                     exp_run_q <= 1'b1;
                  end
               end
               S_EXP_FIN: begin
                  exch_valid_q  <= 1'b1;
                  exch_parity_q <= iter_count_q[0];
                  state_q       <= S_EXCH;
               end
               S_EXCH: begin
                  if (last_iter_d) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     iter_count_q <= iter_count_d;
                     opt_sel_q    <= ~opt_sel_q;
                     cnt_q        <= OPT_LOAD;
                     opt_run_q    <= 1'b1;
                     state_q      <= S_OPT;
                  end
               end
               S_DONE: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus_io.busy        = busy_q;
   assign bus_io.done        = done_q;
   assign bus_io.iter_count  = iter_count_q;
   assign bus_io.opt_run     = opt_run_q;
   assign bus_io.opt_sel     = opt_sel_q;
   assign bus_io.exp_init    = exp_init_q;
   assign bus_io.exp_run     = exp_run_q;
   assign bus_io.exp_fin     = exp_fin_q;
   assign bus_io.exp_recip   = exp_recip_q;
   assign bus_io.exch_valid  = exch_valid_q;
   assign bus_io.exch_parity = exch_parity_q;

endmodule

// File: tb/tb_anneal_seq.sv
// Scoreboard bench for anneal_seq: stimulus queues expected phase strobes,
// a negedge monitor pops and compares whenever any phase strobe is presented.
module tb_anneal_seq;
   localparam int ITER_W   = 24;
   localparam int OPT      = 16;
   localparam int EXP      = 18;
   localparam int ITER_LEN = OPT + EXP + 3;

   localparam logic [5:0] PH_OPT  = 6'b100000;
   localparam logic [5:0] PH_INIT = 6'b010000;
   localparam logic [5:0] PH_RUN  = 6'b001000;
   localparam logic [5:0] PH_FIN  = 6'b000100;
   localparam logic [5:0] PH_EXCH = 6'b000010;
   localparam logic [5:0] PH_DONE = 6'b000001;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   anneal_seq_if #(.ITER_W(ITER_W)) bus ();

   anneal_seq #(
      .OPT_CYCLES(OPT),
      .EXP_CYCLES(EXP),
      .ITER_W(ITER_W)
   ) dut (
      .clk_i(clk),
      .reset_i(reset),
      .bus_io(bus)
   );

   typedef struct {
      int                cyc;
      logic [5:0]        ph;
      logic              sel;
      logic              par;
      logic [ITER_W-1:0] cnt;
      logic [16:0]       recip;
   } ev_t;

   ev_t  sbq[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;
   ev_t  mon_e;
   logic mon_par;
   logic [5:0] ph_now;

   assign ph_now = {bus.opt_run, bus.exp_init, bus.exp_run, bus.exp_fin, bus.exch_valid, bus.done};

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (mon_en) begin
         while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL missing_event cyc=%0d: got phases=%b, required phases=%b", sbq[0].cyc, 6'b0, sbq[0].ph);
            mon_e = sbq.pop_front();
         end
         if (ph_now != 6'b0) begin
            n_chk++;
            if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
               n_fail++;
               $display("FAIL unexpected_output cyc=%0d: got phases=%b, required none", cyc, ph_now);
            end else begin
               mon_e   = sbq.pop_front();
               mon_par = bus.exch_valid ? bus.exch_parity : 1'b0;
               if ({ph_now, bus.busy, bus.opt_sel, mon_par, bus.iter_count, bus.exp_recip} !==
                   {mon_e.ph, 1'b1, mon_e.sel, mon_e.par, mon_e.cnt, mon_e.recip}) begin
                  n_fail++;
                  $display("FAIL phase_event cyc=%0d: got ph=%b busy=%b sel=%b par=%b cnt=%0d recip=%h, required ph=%b busy=1 sel=%b par=%b cnt=%0d recip=%h",
                           cyc, ph_now, bus.busy, bus.opt_sel, mon_par, bus.iter_count, bus.exp_recip,
                           mon_e.ph, mon_e.sel, mon_e.par, mon_e.cnt, mon_e.recip);
               end
            end
         end
      end
   end

   function automatic void push_ev(int c, logic [5:0] ph, logic sel, logic par,
                                   logic [ITER_W-1:0] cnt, logic [16:0] r);
      ev_t e;
      e.cyc   = c;
      e.ph    = ph;
      e.sel   = sel;
      e.par   = par;
      e.cnt   = cnt;
      e.recip = r;
      sbq.push_back(e);
   endfunction

   // Queue every strobe of an n-iteration run started at t0, up to cycle t0+upto.
   task automatic expect_run(int t0, int n, logic [16:0] r, int upto);
      int base;
      logic [5:0] ph;
      logic [ITER_W-1:0] last;
      for (int it = 0; it < n; it++) begin
         base = t0 + it * ITER_LEN;
         for (int c = 1; c <= ITER_LEN; c++) begin
            if (c <= OPT)                ph = PH_OPT;
            else if (c == OPT + 1)       ph = PH_INIT;
            else if (c <= OPT + 1 + EXP) ph = PH_RUN;
            else if (c == OPT + EXP + 2) ph = PH_FIN;
            else                         ph = PH_EXCH;
            if (base + c <= t0 + upto)
               push_ev(base + c, ph, it[0], (ph == PH_EXCH) ? it[0] : 1'b0, ITER_W'(it), r);
         end
      end
      last = (n == 0) ? '0 : ITER_W'(n - 1);
      if (n * ITER_LEN + 1 <= upto)
         push_ev(t0 + n * ITER_LEN + 1, PH_DONE, last[0], 1'b0, last, r);
   endtask

   task automatic check(string name, logic [63:0] got, logic [63:0] req);
      n_chk++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(int c);
      while (cyc < c) step();
   endtask

   function automatic logic [63:0] all_outs();
      return {14'b0, bus.busy, bus.done, bus.iter_count, bus.opt_run, bus.opt_sel,
              bus.exp_init, bus.exp_run, bus.exp_fin, bus.exp_recip,
              bus.exch_valid, bus.exch_parity};
   endfunction

   function automatic logic [63:0] ctl_outs();
      return {33'b0, bus.busy, bus.done, bus.iter_count, bus.opt_run, bus.opt_sel,
              bus.exp_init, bus.exp_run, bus.exp_fin, bus.exch_valid, bus.exch_parity};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.iter_num    = '0;
      bus.recip_write = 1'b0;
      bus.recip_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", all_outs(), 64'h0);
      reset  = 1'b0;
      mon_en = 1'b1;
      step();

      bus.recip_write = 1'b1;
      bus.recip_wdata = 17'h1ABCD;
      step();
      bus.recip_write = 1'b0;
      check("recip_idle_write", 64'(bus.exp_recip), 64'h1ABCD);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check("abort_in_idle", ctl_outs(), 64'h0);

      // One iteration, with an ignored second start and a blocked recip write
      t0 = cyc;
      expect_run(t0, 1, 17'h1ABCD, 1000);
      bus.iter_num = 24'd1;
      bus.start    = 1'b1;
      step();
      bus.start = 1'b0;
      wait_to(t0 + 10);
      bus.start    = 1'b1;
      bus.iter_num = 24'd5;
      step();
      bus.start = 1'b0;
      wait_to(t0 + 20);
      bus.recip_write = 1'b1;
      bus.recip_wdata = 17'h00001;
      step();
      bus.recip_write = 1'b0;
      wait_to(t0 + 37);
      check("t1_exch_c37", {62'b0, bus.exch_valid, bus.exch_parity}, 64'h2);
      wait_to(t0 + 38);
      check("t1_done_c38", {62'b0, bus.done, bus.busy}, 64'h3);
      wait_to(t0 + 39);
      check("t1_idle_c39", {62'b0, bus.done, bus.busy}, 64'h0);
      check("t1_iter_count", 64'(bus.iter_count), 64'h0);
      check("t1_recip_kept", 64'(bus.exp_recip), 64'h1ABCD);

      // Zero iterations
      step();
      t0 = cyc;
      expect_run(t0, 0, 17'h1ABCD, 1000);
      bus.iter_num = 24'd0;
      bus.start    = 1'b1;
      step();
      bus.start = 1'b0;
      check("zero_done_c1", {62'b0, bus.busy, bus.done}, 64'h3);
      step();
      check("zero_idle_c2", ctl_outs(), 64'h0);

      // Two iterations, recip written in the start cycle
      step();
      t0 = cyc;
      expect_run(t0, 2, 17'h0F0F0, 1000);
      bus.iter_num    = 24'd2;
      bus.start       = 1'b1;
      bus.recip_write = 1'b1;
      bus.recip_wdata = 17'h0F0F0;
      step();
      bus.start       = 1'b0;
      bus.recip_write = 1'b0;
      check("t2_recip_c1", 64'(bus.exp_recip), 64'h0F0F0);
      wait_to(t0 + 74);
      check("t2_exch_c74", {61'b0, bus.exch_valid, bus.exch_parity, bus.opt_sel}, 64'h7);
      wait_to(t0 + 75);
      check("t2_done_c75", {62'b0, bus.done, bus.busy}, 64'h3);
      wait_to(t0 + 76);
      check("t2_busy_c76", 64'(bus.busy), 64'h0);
      check("t2_iter_count", 64'(bus.iter_count), 64'h1);

      // Three iterations aborted at cycle 50, then restart with abort+start together
      step();
      t0 = cyc;
      expect_run(t0, 3, 17'h0F0F0, 50);
      bus.iter_num = 24'd3;
      bus.start    = 1'b1;
      step();
      bus.start = 1'b0;
      wait_to(t0 + 50);
      check("abort_pre_sel", 64'(bus.opt_sel), 64'h1);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check("abort_outputs_c51", ctl_outs(), 64'h0);
      wait_to(t0 + 60);
      expect_run(t0 + 60, 1, 17'h0F0F0, 1000);
      bus.iter_num = 24'd1;
      bus.start    = 1'b1;
      bus.abort    = 1'b1;
      step();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("restart_c1", {60'b0, bus.busy, bus.opt_run, bus.opt_sel, bus.iter_count[0]}, 64'hC);
      wait_to(t0 + 60 + 39);
      check("restart_idle", 64'(bus.busy), 64'h0);

      // Asynchronous reset at cycle 20
      step();
      t0 = cyc;
      expect_run(t0, 1, 17'h0F0F0, 19);
      bus.iter_num = 24'd1;
      bus.start    = 1'b1;
      step();
      bus.start = 1'b0;
      wait_to(t0 + 20);
      reset = 1'b1;
      #1;
      check("async_reset_outputs", all_outs(), 64'h0);
      step();
      reset = 1'b0;
      step();
      check("post_reset_idle", all_outs(), 64'h0);
      t0 = cyc;
      expect_run(t0, 1, 17'h0, 1000);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_to(t0 + 38);
      check("post_reset_done", {62'b0, bus.done, bus.busy}, 64'h3);

      repeat (3) step();
      check("scoreboard_drained", 64'(sbq.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
